router_dst_rcv: RTL
===================

// Module: router_dst_rcv
// PURPOSE
// Destination-side receiver for one 1x3 router output port. Sits at the far end from the source
// driver: watches vld_out, raises read_enb after a programmable delay, drains one packet
// (header, payload, parity), streams payload bytes out, and reports length, address, parity and
// address errors. It also keeps saturating packet and error counters. Used as the synthesizable
// sink/checker on each router output.
// PARAMETERS
// READ_DELAY  5   cycles from vld_out rising (in IDLE) to first read_enb; legal 0..29 (< router 30-cycle soft reset)
// STALL_MAX   32  cycles with no byte captured while in READ before the packet is aborted
// PORT_ID     0   expected header addr[1:0] for this output port
// CNT_W       16  width of pkt_cnt / err_cnt
// PORTS
// clock      in   1      single clock, all logic on posedge
// reset      in   1      synchronous, active-high
// vld_out    in   1      router output FIFO non-empty
// data_out   in   8      router FIFO read data; valid the cycle after read_enb=1 && vld_out=1
// read_enb   out  1      FIFO pop request
// pay_data   out  8      captured payload byte
// pay_valid  out  1      1-cycle qualifier for pay_data
// pkt_done   out  1      1-cycle pulse: parity byte captured
// pkt_len    out  6      header[7:2] of the last completed packet, held until the next pkt_done
// pkt_addr   out  2      header[1:0] of the last completed packet, held until the next pkt_done
// parity_err out  1      valid with pkt_done: XOR of all bytes incl. parity != 0
// addr_err   out  1      valid with pkt_done: header[1:0] != PORT_ID
// pkt_abort  out  1      1-cycle pulse: stall timeout, packet discarded
// rcv_busy   out  1      1 in every state except IDLE
// pkt_cnt    out  CNT_W  completed packets, saturating
// err_cnt    out  CNT_W  packets with parity_err|addr_err, plus aborts; saturating
// BEHAVIOUR
// - Reset: state=IDLE. Every output is 0, including both counters, pkt_len and pkt_addr.
//   Reset in any state discards the packet in progress with no pkt_done or pkt_abort.
// - Packet format: header {len[5:0], addr[1:0]}, then len payload bytes, then 1 parity byte.
//   total = len+2 bytes. len=0 is legal: header then parity, no pay_valid.
// - rd_q: registered (read_enb & vld_out). A byte is captured from data_out in every cycle with rd_q=1.
// - IDLE: read_enb=0. vld_out=1 -> WAIT with dly=READ_DELAY.
// - WAIT: dly decrements each cycle; at dly==0 -> READ. READ_DELAY=0 enters READ the cycle after vld_out is seen.
// - READ: read_enb = vld_out && (issued < total). Before the header is captured, total is treated as
//   unbounded; at most 2 reads are issued before len is known, and 2 <= minimum total.
//   - issued: count of read_enb&vld_out cycles. captured: count of rd_q cycles.
//   - Byte 0 loads the len/addr shadow. Bytes 1..len drive pay_data/pay_valid one cycle after capture.
//     Every byte XORs into the running parity.
//   - Last byte (captured==total-1) -> DONE. Running XOR, including this byte, is the parity result.
//   - vld_out low mid-packet: read_enb drops and reading resumes when vld_out returns, with no byte lost.
//   - stall counter resets on each rd_q and increments otherwise. Reaching STALL_MAX -> pkt_abort pulse,
//     err_cnt+1, back to IDLE. pkt_len/pkt_addr are not updated.
// - DONE, 1 cycle: pkt_done=1. pkt_len/pkt_addr are updated. parity_err and addr_err are valid this cycle only.
//   pkt_cnt+1; err_cnt+1 if either error. Next state is IDLE.
//   If vld_out=1 in this cycle, the next packet's WAIT starts the following cycle.
// - Latency, READ_DELAY=d, no stalls: read_enb first high d+1 cycles after vld_out rises.
//   pkt_done is 2 cycles after the last read_enb cycle.
// - Counters hold at 2^CNT_W-1. Simultaneous error and abort cannot occur (exclusive states).
// TESTING
// 1 hdr 8'h0C (len3, addr0), payload 11 22 33, parity 0C^11^22^33=0C, READ_DELAY=5 -> read_enb 6 cyc after vld_out,
//   pay_valid x3 = 11,22,33, pkt_done with parity_err=0, pkt_len=3, pkt_cnt=1
// 2 same packet with parity byte 8'h0D -> pkt_done with parity_err=1, err_cnt=1, pkt_cnt=1
// 3 hdr 8'h01 (len0, addr1), PORT_ID=0, parity 01 -> no pay_valid, addr_err=1, parity_err=0, pkt_len=0
// 4 len 4 packet, vld_out low for 3 cycles after byte 2 -> read_enb drops and resumes, all 6 bytes captured in order, no abort
// 5 vld_out stuck low after header, STALL_MAX=32 -> pkt_abort 32 cycles after last capture, err_cnt+1, rcv_busy=0 next cycle
// 6 two back-to-back len1 packets (vld_out stays high); reset asserted mid-2nd -> pkt_cnt=0, all outputs 0, next packet received cleanly

Source files
------------

// File: rtl/router_dst_rcv.sv
// Destination-side receiver for one router output port: waits a programmable delay after
// vld_out, drains one packet (header, payload, parity), streams payload and flags errors.
module router_dst_rcv #(
    parameter int         READ_DELAY = 5,
    parameter int         STALL_MAX  = 32,
    parameter logic [1:0] PORT_ID    = 2'd0,
    parameter int         CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             vld_out,
    input  logic [7:0]       data_out,
    output logic             read_enb,
    output logic [7:0]       pay_data,
    output logic             pay_valid,
    output logic             pkt_done,
    output logic [5:0]       pkt_len,
    output logic [1:0]       pkt_addr,
    output logic             parity_err,
    output logic             addr_err,
    output logic             pkt_abort,
    output logic             rcv_busy,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int         STALL_W    = $clog2(STALL_MAX + 1);
    localparam logic [4:0] DLY_INIT   = (READ_DELAY > 0) ? 5'(READ_DELAY - 1) : 5'd0;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [4:0]         dly;
    logic [6:0]         issued;
    logic [6:0]         captured;
    logic [6:0]         total;
    logic               hdr_known;
    logic [5:0]         len_sh;
    logic [1:0]         addr_sh;
    logic [7:0]         par;
    logic               rd_q;
    logic [STALL_W-1:0] stall;
    logic               perr_q;
    logic               last_byte;
    logic               abort;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign total     = {1'b0, len_sh} + 7'd2;
    assign last_byte = rd_q && hdr_known && (captured == total - 7'd1);
    assign abort     = (state == S_READ) && !rd_q && (stall == STALL_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DONE doubles as IDLE so a queued packet starts its delay without a gap cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (vld_out) begin
                    if (READ_DELAY == 0) state_nxt = S_READ;
                    else                 state_nxt = S_WAIT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: if (dly == 5'd0) state_nxt = S_READ;
            S_READ: begin
                if (abort)          state_nxt = S_IDLE;
                else if (last_byte) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        read_enb   = 1'b0;
        pkt_done   = 1'b0;
        parity_err = 1'b0;
        addr_err   = 1'b0;
        pkt_abort  = 1'b0;
        rcv_busy   = (state != S_IDLE);
        case (state)
            S_READ: begin
                // Header not yet seen: allow two reads, the minimum packet size
                read_enb  = vld_out && !abort && (hdr_known ? (issued < total) : (issued < 7'd2));
                pkt_abort = abort;
            end
            S_DONE: begin
                pkt_done   = 1'b1;
                parity_err = perr_q;
                addr_err   = (addr_sh != PORT_ID);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dly       <= 5'd0;
            issued    <= 7'd0;
            captured  <= 7'd0;
            hdr_known <= 1'b0;
            rd_q      <= 1'b0;
            stall     <= '0;
            perr_q    <= 1'b0;
            pay_data  <= 8'd0;
            pay_valid <= 1'b0;
            pkt_len   <= 6'd0;
            pkt_addr  <= 2'd0;
            pkt_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            rd_q      <= read_enb;
            pay_valid <= 1'b0;
            if (state == S_WAIT) dly <= dly - 5'd1;
            else                 dly <= DLY_INIT;

            if (state != S_READ) begin
                issued    <= 7'd0;
                captured  <= 7'd0;
                hdr_known <= 1'b0;
                stall     <= '0;
            end else begin
                if (read_enb) issued <= issued + 7'd1;
                stall <= rd_q ? '0 : stall + STALL_W'(1);
                if (rd_q) begin
                    captured <= captured + 7'd1;
                    if (captured == 7'd0) begin
                        hdr_known <= 1'b1;
                    end else if ({1'b0, len_sh} >= captured) begin
                        pay_data  <= data_out;
                        pay_valid <= 1'b1;
                    end
                    if (last_byte) begin
                        pkt_len  <= len_sh;
                        pkt_addr <= addr_sh;
                        perr_q   <= ((par ^ data_out) != 8'd0);
                    end
                end
            end

            if (state == S_DONE) begin
                pkt_cnt <= sat_inc(pkt_cnt);
                if (parity_err || addr_err) err_cnt <= sat_inc(err_cnt);
            end
            if (abort) err_cnt <= sat_inc(err_cnt);
        end
    end

    // Header shadow and running parity are always reloaded by byte 0, so they carry no reset
    always_ff @(posedge clock) begin
        if (state == S_READ && rd_q) begin
            if (captured == 7'd0) begin
                len_sh  <= data_out[7:2];
                addr_sh <= data_out[1:0];
                par     <= data_out;
            end else begin
                par <= par ^ data_out;
            end
        end
    end

endmodule
